// File: rtl/bist_seq_pkg.sv
// Shared state encoding, registered-output bundle and sizing helper for the BIST boot sequencer.
// Pure declarations: no latency, no backpressure.
package bist_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    START_HOLD,
    RUN,
    EVAL,
    BOOT,
    FAIL
  } seq_state_e;

  typedef struct packed {
    logic bist_rst_n;
    logic start_test;
    logic core_rst_n;
    logic fetch_enable;
    logic done;
    logic pass;
    logic fail;
    logic timeout;
  } seq_out_t;

  localparam seq_out_t OUT_RESET = '{
    bist_rst_n:   1'b0,
    start_test:   1'b1,
    core_rst_n:   1'b0,
    fetch_enable: 1'b0,
    done:         1'b0,
    pass:         1'b0,
    fail:         1'b0,
    timeout:      1'b0
  };

  // Bits needed to hold max_count itself, never less than one.
  function automatic int unsigned timer_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/bist_cycle_timer.sv
// Loadable saturating up-counter with synchronous clear and a terminal-count compare.
// Count changes one edge after clr/load/inc; tc_o is combinational on the held count; no backpressure.
module bist_cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] tc_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/bist_boot_sequencer.sv
// Holds the core in reset, runs BIST via start/busy/go handshake with optional retries, boots on pass.
// All outputs registered; busy-fall to core reset release is 2 edges; no backpressure.
module bist_boot_sequencer
  import bist_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned RUN_TIMEOUT  = 1000000,
  parameter int unsigned MAX_RETRIES  = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  restart_i,
  input  logic                                  bist_busy_i,
  input  logic                                  bist_go_i,
  output logic                                  bist_rst_no,
  output logic                                  start_test_o,
  output logic                                  core_rst_no,
  output logic                                  fetch_enable_o,
  output logic                                  done_o,
  output logic                                  pass_o,
  output logic                                  fail_o,
  output logic                                  timeout_o,
  output logic [timer_width(MAX_RETRIES)-1:0]   retry_cnt_o
);

  localparam int unsigned HOLD_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
  localparam int unsigned TW = timer_width((RUN_TIMEOUT > HOLD_MAX) ? RUN_TIMEOUT : HOLD_MAX);
  localparam int unsigned RW = timer_width(MAX_RETRIES);

  // Hold states leave on the edge that completes their last cycle, so compare against N-1.
  localparam logic [TW-1:0] RESET_TC = TW'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);
  localparam logic [TW-1:0] START_TC = TW'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
  localparam logic [TW-1:0] RUN_TC   = TW'(RUN_TIMEOUT);
  localparam logic [TW-1:0] RUN_FIRST = TW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  seq_state_e      state_q, state_d;
  seq_out_t        out_q, out_d;
  logic [RW-1:0]   retry_q, retry_d;

  logic            tmr_clr, tmr_load, tmr_inc, tmr_tc;
  logic [TW-1:0]   tmr_tc_val, tmr_cnt;

  bist_cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .inc_i      (tmr_inc),
    .load_val_i (RUN_FIRST),
    .tc_val_i   (tmr_tc_val),
    .cnt_o      (tmr_cnt),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    retry_d    = retry_q;
    tmr_clr    = 1'b0;
    tmr_load   = 1'b0;
    tmr_inc    = 1'b0;
    tmr_tc_val = '0;

    case (state_q)
      RESET_HOLD: begin
        tmr_inc    = 1'b1;
        tmr_tc_val = RESET_TC;
        if (tmr_tc) begin
          state_d          = START_HOLD;
          out_d.bist_rst_n = 1'b1;
          tmr_clr          = 1'b1;
        end
      end
      START_HOLD: begin
        tmr_inc    = 1'b1;
        tmr_tc_val = START_TC;
        if (tmr_tc) begin
          state_d          = RUN;
          out_d.start_test = 1'b0;
          tmr_load         = 1'b1;
        end
      end
      RUN: begin
        tmr_inc    = 1'b1;
        tmr_tc_val = RUN_TC;
        // Busy is not yet meaningful in the launch cycle; a real fall beats a same-cycle timeout.
        if ((tmr_cnt != RUN_FIRST) && !bist_busy_i) begin
          state_d = EVAL;
        end else if (tmr_tc) begin
          state_d       = FAIL;
          out_d.timeout = 1'b1;
          out_d.fail    = 1'b1;
          out_d.done    = 1'b1;
        end
      end
      EVAL: begin
        if (bist_go_i) begin
          state_d          = BOOT;
          out_d.core_rst_n = 1'b1;
        end else if (retry_q < RETRY_MAX) begin
          state_d          = RESET_HOLD;
          retry_d          = retry_q + 1'b1;
          out_d.bist_rst_n = 1'b0;
          out_d.start_test = 1'b1;
          tmr_clr          = 1'b1;
        end else begin
          state_d    = FAIL;
          out_d.fail = 1'b1;
          out_d.done = 1'b1;
        end
      end
      BOOT: begin
        if (restart_i) begin
          state_d = RESET_HOLD;
          out_d   = OUT_RESET;
          retry_d = '0;
          tmr_clr = 1'b1;
        end else begin
          out_d.fetch_enable = 1'b1;
          out_d.pass         = 1'b1;
          out_d.done         = 1'b1;
        end
      end
      FAIL: begin
        if (restart_i) begin
          state_d = RESET_HOLD;
          out_d   = OUT_RESET;
          retry_d = '0;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = RESET_HOLD;
        out_d   = OUT_RESET;
        retry_d = '0;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_HOLD;
      out_q   <= OUT_RESET;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      retry_q <= retry_d;
    end
  end

  assign bist_rst_no    = out_q.bist_rst_n;
  assign start_test_o   = out_q.start_test;
  assign core_rst_no    = out_q.core_rst_n;
  assign fetch_enable_o = out_q.fetch_enable;
  assign done_o         = out_q.done;
  assign pass_o         = out_q.pass;
  assign fail_o         = out_q.fail;
  assign timeout_o      = out_q.timeout;
  assign retry_cnt_o    = retry_q;

endmodule

// File: tb/tb_bist_boot_sequencer.sv
// Directed bench for bist_boot_sequencer: default, retry-enabled and short-timeout instances.
// Inputs change 1 time unit after a rising edge; outputs are checked there as well.
module tb_bist_boot_sequencer;

  logic       clk_i = 1'b0;
  logic [2:0] rst     = 3'b111;
  logic [2:0] restart = 3'b000;
  logic [2:0] busy    = 3'b111;
  logic [2:0] go      = 3'b111;

  logic [2:0] brn, st, crn, fe, dn, ps, fl, to;
  logic       rc0, rc2;
  logic [1:0] rc1;

  int checks = 0;
  int errors = 0;

  // {bist_rst_no, start_test_o, core_rst_no, fetch_enable_o, done, pass, fail, timeout}
  localparam logic [7:0] RST_OUTS = 8'b0100_0000;

  always #5 clk_i = ~clk_i;

  bist_boot_sequencer u_def (
    .clk_i (clk_i), .rst_i (rst[0]), .restart_i (restart[0]),
    .bist_busy_i (busy[0]), .bist_go_i (go[0]),
    .bist_rst_no (brn[0]), .start_test_o (st[0]), .core_rst_no (crn[0]),
    .fetch_enable_o (fe[0]), .done_o (dn[0]), .pass_o (ps[0]), .fail_o (fl[0]),
    .timeout_o (to[0]), .retry_cnt_o (rc0)
  );

  bist_boot_sequencer #(.MAX_RETRIES(2)) u_rty (
    .clk_i (clk_i), .rst_i (rst[1]), .restart_i (restart[1]),
    .bist_busy_i (busy[1]), .bist_go_i (go[1]),
    .bist_rst_no (brn[1]), .start_test_o (st[1]), .core_rst_no (crn[1]),
    .fetch_enable_o (fe[1]), .done_o (dn[1]), .pass_o (ps[1]), .fail_o (fl[1]),
    .timeout_o (to[1]), .retry_cnt_o (rc1)
  );

  bist_boot_sequencer #(.RUN_TIMEOUT(20)) u_to (
    .clk_i (clk_i), .rst_i (rst[2]), .restart_i (restart[2]),
    .bist_busy_i (busy[2]), .bist_go_i (go[2]),
    .bist_rst_no (brn[2]), .start_test_o (st[2]), .core_rst_no (crn[2]),
    .fetch_enable_o (fe[2]), .done_o (dn[2]), .pass_o (ps[2]), .fail_o (fl[2]),
    .timeout_o (to[2]), .retry_cnt_o (rc2)
  );

  function automatic logic [7:0] outs(input int i);
    return {brn[i], st[i], crn[i], fe[i], dn[i], ps[i], fl[i], to[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    tick(2);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outs%0d", i), outs(i), RST_OUTS);
    chk("reset_retry0", rc0, 0);
    chk("reset_retry1", rc1, 0);

    // Default instance: pass path, start_test falls at edge 6
    rst[0] = 1'b0;
    tick(3);
    chk("bist_rst_low_e3", brn[0], 0);
    tick(1);
    chk("bist_rst_high_e4", brn[0], 1);
    chk("start_high_e4", st[0], 1);
    tick(1);
    chk("start_high_e5", st[0], 1);
    tick(1);
    chk("start_fall_e6", st[0], 0);
    tick(10);
    chk("run_no_core", crn[0], 0);
    chk("run_not_done", dn[0], 0);
    busy[0] = 1'b0;
    go[0]   = 1'b1;
    tick(1);
    chk("eval_core_held", crn[0], 0);
    tick(1);
    chk("boot_core_rel", crn[0], 1);
    chk("boot_fetch_late", fe[0], 0);
    chk("boot_pass_late", ps[0], 0);
    tick(1);
    chk("boot_fetch", fe[0], 1);
    chk("boot_pass", ps[0], 1);
    chk("boot_done", dn[0], 1);
    chk("boot_no_fail", fl[0], 0);

    // Restart from BOOT, busy already low in first RUN cycle, restart ignored in RUN
    restart[0] = 1'b1;
    tick(1);
    restart[0] = 1'b0;
    chk("restart_boot_outs", outs(0), RST_OUTS);
    tick(6);
    chk("rerun_start_fall", st[0], 0);
    restart[0] = 1'b1;
    tick(1);
    restart[0] = 1'b0;
    chk("run_restart_ignored", {brn[0], st[0], dn[0], crn[0]}, 4'b1000);
    tick(1);
    chk("busy_first_ignored", crn[0], 0);
    tick(1);
    chk("busy_c2_accepted", crn[0], 1);

    // Asynchronous reset mid-RUN
    restart[0] = 1'b1;
    tick(1);
    restart[0] = 1'b0;
    busy[0]    = 1'b1;
    tick(9);
    chk("midrun_pre", {brn[0], st[0]}, 2'b10);
    rst[0] = 1'b1;
    #1;
    chk("async_rst_outs", outs(0), RST_OUTS);
    tick(1);
    rst[0] = 1'b0;

    // go=0 without retries parks in FAIL
    tick(9);
    busy[0] = 1'b0;
    go[0]   = 1'b0;
    tick(2);
    chk("nogo_fail", outs(0), 8'b1000_0010 | 8'b0000_1000);
    tick(20);
    chk("fail_core_held", {crn[0], fe[0], fl[0], dn[0]}, 4'b0011);

    // Restart from FAIL runs the full sequence into BOOT
    restart[0] = 1'b1;
    busy[0]    = 1'b1;
    go[0]      = 1'b1;
    tick(1);
    restart[0] = 1'b0;
    chk("restart_fail_outs", outs(0), RST_OUTS);
    tick(8);
    busy[0] = 1'b0;
    tick(2);
    chk("refail_boot_core", crn[0], 1);
    tick(1);
    chk("refail_boot_pass", {ps[0], fl[0]}, 2'b10);
    chk("refail_retry", rc0, 0);

    // Retry instance: go=0 then go=1
    rst[1] = 1'b0;
    tick(6);
    chk("rty_start_fall", st[1], 0);
    tick(2);
    busy[1] = 1'b0;
    go[1]   = 1'b0;
    tick(1);
    chk("rty_eval_bist_rst", brn[1], 1);
    tick(1);
    chk("rty_bist_rst_low", brn[1], 0);
    chk("rty_start_high", st[1], 1);
    chk("rty_cnt1", rc1, 1);
    busy[1] = 1'b1;
    go[1]   = 1'b1;
    tick(3);
    chk("rty_hold_e3", brn[1], 0);
    tick(1);
    chk("rty_release_e4", brn[1], 1);
    tick(2);
    chk("rty_start_fall2", st[1], 0);
    tick(2);
    busy[1] = 1'b0;
    tick(2);
    chk("rty_core_rel", crn[1], 1);
    tick(1);
    chk("rty_pass", {ps[1], fl[1], dn[1]}, 3'b101);
    chk("rty_cnt_final", rc1, 1);

    // Timeout instance: busy stuck high times out at RUN cycle 20
    rst[2] = 1'b0;
    tick(25);
    chk("to_c19_none", {to[2], fl[2]}, 2'b00);
    tick(1);
    chk("to_c20_timeout", {to[2], fl[2], dn[2], crn[2]}, 4'b1110);

    // Busy falling exactly at cycle 20 wins over the timeout
    restart[2] = 1'b1;
    tick(1);
    restart[2] = 1'b0;
    chk("to_restart_outs", outs(2), RST_OUTS);
    tick(25);
    busy[2] = 1'b0;
    go[2]   = 1'b1;
    tick(1);
    chk("to_busy_wins", {to[2], fl[2], dn[2]}, 3'b000);
    tick(1);
    chk("to_boot_core", crn[2], 1);
    tick(1);
    chk("to_boot_pass", {ps[2], to[2]}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_boot_sequencer.md
# bist_boot_sequencer

Power-on sequencer between the system reset and the RI5CY core wrapper. It holds the core in reset, runs the on-chip BIST engine via its start/busy/go-no-go handshake, and optionally retries a failed BIST. The core's reset is released and instruction fetch enabled only after a BIST pass. A timeout or exhausted retries parks the block in a terminal FAIL state with the core still held in reset.

## Interface
- RESET_CYCLES, 4: cycles the BIST is held in reset after rst_i deasserts
- START_CYCLES, 2: cycles start_test_o stays high after BIST reset release
- RUN_TIMEOUT, 1000000: maximum RUN cycles before declaring timeout
- MAX_RETRIES, 0: BIST re-runs allowed after a no-go
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- restart_i  in  1  single-cycle pulse; honoured only in BOOT or FAIL
- bist_busy_i  in  1  BIST test_o, high while testing
- bist_go_i  in  1  BIST go_nogo, valid when busy falls
- bist_rst_no  out  1  BIST reset, active-low
- start_test_o  out  1  BIST start_test; falling edge launches test
- core_rst_no  out  1  core reset, active-low
- fetch_enable_o  out  1  core fetch enable
- done_o / pass_o / fail_o / timeout_o  out  1 each  status flags
- retry_cnt_o  out  $clog2(MAX_RETRIES+1) (min 1)  retries consumed

## Operation
- All outputs registered. Reset values: bist_rst_no=0, start_test_o=1, core_rst_no=0, fetch_enable_o=0, done/pass/fail/timeout=0, retry_cnt_o=0; state RESET_HOLD, counter 0.
- RESET_HOLD: count RESET_CYCLES cycles, then go to START_HOLD and set bist_rst_no=1.
- START_HOLD: start_test_o stays 1 for START_CYCLES cycles, then go to RUN and set start_test_o=0.
- RUN: the cycle timer counts from 1.
  - bist_busy_i is ignored in the first RUN cycle (BIST launch latency).
  - From the second cycle on, bist_busy_i=0 goes to EVAL.
  - If the timer reaches RUN_TIMEOUT with busy still high, go to FAIL with timeout_o=1.
  - If busy falls on the same cycle the timer reaches RUN_TIMEOUT, busy wins and the block goes to EVAL.
- EVAL: one cycle; sample bist_go_i.
  - 1 goes to BOOT.
  - 0 with retry_cnt < MAX_RETRIES: increment retry_cnt, go to RESET_HOLD, drive bist_rst_no=0 and start_test_o=1.
  - Otherwise go to FAIL.
- BOOT: core_rst_no=1 on entry; fetch_enable_o=1 one cycle later; pass_o=1 and done_o=1 at the same cycle as fetch_enable_o. Terminal.
- FAIL: fail_o=1, done_o=1; core_rst_no and fetch_enable_o stay 0. Terminal.
- restart_i in BOOT/FAIL returns all outputs to their reset values and re-enters RESET_HOLD next cycle; it is ignored in all other states.
- rst_i asserted in any state, including mid-RUN, forces reset values immediately (asynchronous).

## Timing
- Without retries, start_test_o falls RESET_CYCLES+START_CYCLES edges after rst_i deasserts.
- Minimum busy-fall to core_rst_no=1: 2 edges (EVAL, then BOOT entry).
- fetch_enable_o rises 1 edge after core_rst_no.
- Each retry restarts the full RESET_HOLD/START_HOLD sequence.
- bist_go_i is sampled only in EVAL and ignored elsewhere.
- The timer saturates and does not wrap.

## Structure
- bist_seq_pkg holds the state enum (RESET_HOLD, START_HOLD, RUN, EVAL, BOOT, FAIL) and a function computing the timer width from RUN_TIMEOUT.
- One sub-module, bist_cycle_timer: a loadable, saturating up-counter with clear and a terminal-count compare, shared by all counting states.

## Test plan
- Default parameters, busy high for 10 RUN cycles, go=1:
  - start_test_o falls at edge 6;
  - core_rst_no rises 2 edges after busy falls, fetch_enable_o 1 edge later;
  - pass_o=1, done_o=1.
- go=0 with MAX_RETRIES=0 leads to FAIL: fail_o=1, core_rst_no stays 0 indefinitely.
- MAX_RETRIES=2, go=0 then go=1: bist_rst_no pulses low again, retry_cnt_o=1, final pass_o=1.
- RUN_TIMEOUT=20, busy stuck high: timeout_o=1 and fail_o=1 at RUN cycle 20. A second run with busy falling exactly at cycle 20 must reach EVAL instead.
- Busy already low in the first RUN cycle: it is ignored and a fall on cycle 2 is accepted; rst_i pulsed mid-RUN returns every output to its reset value in the same cycle.
- restart_i pulsed in FAIL re-runs the full sequence and ends in BOOT; restart_i pulsed during RUN has no effect.
